// File: rtl/winograd_stitch_ctrl.sv
// Assembles a TRxTC grid of Winograd output tiles into an OUT_H x OUT_W image and streams it out row by row.
// Define WINO_STITCH_PINGPONG_EN for two image buffers (fill one while draining the other); default is one buffer.
module winograd_stitch_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE       = 4,
  parameter int OUT_H      = 8,
  parameter int OUT_W      = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              tile_valid,
  output logic                              tile_ready,
  input  logic [TILE*TILE*DATA_WIDTH-1:0]   tile_data,
  output logic                              row_valid,
  input  logic                              row_ready,
  output logic [OUT_W*DATA_WIDTH-1:0]       row_data,
  output logic [$clog2(OUT_H)-1:0]          row_idx,
  output logic                              row_last,
  output logic                              frame_done,
  output logic                              busy
);
  localparam int TR  = (OUT_H + TILE - 1) / TILE;
  localparam int TC  = (OUT_W + TILE - 1) / TILE;
  localparam int TRW = (TR > 1) ? $clog2(TR) : 1;
  localparam int TCW = (TC > 1) ? $clog2(TC) : 1;
  localparam int RW  = $clog2(OUT_H);
`ifdef WINO_STITCH_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                                          state;
  logic [NBUF-1:0][OUT_H-1:0][OUT_W-1:0][DATA_WIDTH-1:0] img, img_d;
  logic [TRW-1:0]  tr;
  logic [TCW-1:0]  tc;
  logic [RW-1:0]   rcnt;
  logic [NBUF-1:0] full, full_nxt;
  logic            fb, db, db_nxt;
  logic            tile_hs, tile_last, fill_done, row_hs, row_end;

  // a handshake coinciding with clear is dropped
  assign tile_hs   = tile_valid && tile_ready && !clear;
  assign tile_last = (tr == TRW'(TR - 1)) && (tc == TCW'(TC - 1));
  assign fill_done = tile_hs && tile_last;
  assign row_hs    = row_valid && row_ready && !clear;
  assign row_end   = row_hs && (rcnt == RW'(OUT_H - 1));

  assign tile_ready = !full[fb];
  assign row_valid  = (state == DRAIN);
  assign row_data   = img[db][rcnt];
  assign row_idx    = rcnt;
  assign row_last   = row_valid && (rcnt == RW'(OUT_H - 1));
  assign busy       = (tr != '0) || (tc != '0) || (|full);

  always_comb begin
    full_nxt = full;
    db_nxt   = db;
    if (fill_done) full_nxt[fb] = 1'b1;
    if (row_end) begin
      full_nxt[db] = 1'b0;
      if (NBUF > 1) db_nxt = ~db;
    end
  end

  // Drain state follows the flag of the buffer next in line, so a frame
  // completing this cycle is presented on the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tr         <= '0;
      tc         <= '0;
      rcnt       <= '0;
      full       <= '0;
      fb         <= 1'b0;
      db         <= 1'b0;
      frame_done <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      tr         <= '0;
      tc         <= '0;
      rcnt       <= '0;
      full       <= '0;
      fb         <= 1'b0;
      db         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (tile_hs) begin
        if (tc == TCW'(TC - 1)) begin
          tc <= '0;
          tr <= tile_last ? '0 : tr + 1'b1;
        end else begin
          tc <= tc + 1'b1;
        end
        if (tile_last && NBUF > 1) fb <= ~fb;
      end
      if (row_hs) rcnt <= row_end ? '0 : rcnt + 1'b1;
      full       <= full_nxt;
      db         <= db_nxt;
      frame_done <= row_end;
      state      <= full_nxt[db_nxt] ? DRAIN : IDLE;
    end
  end

  // Only in-image pixels exist, so out-of-range tile elements are never stored.
  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    for (genvar y = 0; y < OUT_H; y++) begin : g_row
      for (genvar x = 0; x < OUT_W; x++) begin : g_col
        localparam int E = (y % TILE) * TILE + (x % TILE);
        logic we;
        assign we = tile_hs && (fb == 1'(b)) && (tr == TRW'(y / TILE)) && (tc == TCW'(x / TILE));
        assign img_d[b][y][x] = we ? tile_data[E*DATA_WIDTH +: DATA_WIDTH] : img[b][y][x];
      end
    end
  end

  always_ff @(posedge clk) img <= img_d;

endmodule

// File: tb/tb_winograd_stitch_ctrl.sv
// Directed bench for winograd_stitch_ctrl: frame assembly, clipping, backpressure, overlap, clear and reset.
module tb_winograd_stitch_ctrl;
  localparam int DW = 16, W = 10, H = 8;
`ifdef WINO_STITCH_PINGPONG_EN
  localparam int PP = 1;
`else
  localparam int PP = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, tile_valid = 1'b0, row_ready = 1'b0;
  logic [16*DW-1:0] tile_data = '0;
  logic tile_ready, row_valid, row_last, frame_done, busy;
  logic [W*DW-1:0] row_data;
  logic [2:0] row_idx;

  winograd_stitch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .row_last(row_last), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int tq_tag[$], tq_k[$], fq[$];
  int erow = 0, fd_cnt = 0, dead_cnt = 0, run = 0, max_run = 0, tr_stall = 0, rv_tr_hi = 0;
  logic [W*DW-1:0] cap [H];
  logic held_v = 1'b0, held_l;
  logic [W*DW-1:0] held_d;
  logic [2:0] held_i;

  function automatic logic [16*DW-1:0] mk_tile(input int tag, input int k);
    logic [16*DW-1:0] t;
    logic [15:0] v;
    int r, c;
    r = k / 3; c = k % 3; t = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (c*4 + j >= W) v = 16'hDEAD;
        else v = {r[3:0], c[3:0], i[3:0], j[3:0]} ^ {tag[3:0], 12'h000};
        t[(i*4+j)*DW +: DW] = v;
      end
    return t;
  endfunction

  function automatic logic [W*DW-1:0] exp_row(input int tag, input int y);
    logic [W*DW-1:0] rw;
    int ry, iy, cx, jx;
    ry = y / 4; iy = y % 4;
    for (int x = 0; x < W; x++) begin
      cx = x / 4; jx = x % 4;
      rw[x*DW +: DW] = {ry[3:0], cx[3:0], iy[3:0], jx[3:0]} ^ {tag[3:0], 12'h000};
    end
    return rw;
  endfunction

  task automatic chk(input string tag, input logic [W*DW-1:0] obs, input logic [W*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input int tag);
    for (int k = 0; k < 6; k++) begin tq_tag.push_back(tag); tq_k.push_back(k); end
    fq.push_back(tag);
  endtask

  // One cycle, called at a negedge: check/record outputs, drive the next tile, advance.
  task automatic step();
    if (held_v) begin
      chk("hold_valid", row_valid, 1);
      chk("hold_data", row_data, held_d);
      chk("hold_idx", row_idx, held_i);
      chk("hold_last", row_last, held_l);
    end
    held_v = row_valid && !row_ready;
    held_d = row_data; held_i = row_idx; held_l = row_last;
    if (row_valid) begin
      run++;
      if (run > max_run) max_run = run;
      for (int x = 0; x < W; x++) if (row_data[x*DW +: DW] == 16'hDEAD) dead_cnt++;
      if (tile_ready) rv_tr_hi++;
    end else run = 0;
    if (frame_done) fd_cnt++;
    if (row_valid && row_ready) begin
      if (fq.size() == 0) chk("unexpected_row", fq.size(), 1);
      else begin
        chk("row_idx", row_idx, erow);
        chk("row_data", row_data, exp_row(fq[0], erow));
        chk("row_last", row_last, erow == H-1);
        cap[erow] = row_data;
        erow++;
        if (erow == H) begin erow = 0; void'(fq.pop_front()); end
      end
    end
    if (tq_tag.size() > 0) begin
      tile_valid = 1'b1;
      tile_data  = mk_tile(tq_tag[0], tq_k[0]);
      if (tile_ready) begin void'(tq_tag.pop_front()); void'(tq_k.pop_front()); end
      else tr_stall++;
    end else tile_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_all(input int bound);
    int n = 0;
    while ((fq.size() > 0 || tq_tag.size() > 0) && n < bound) begin step(); n++; end
    chk("drain_timeout", n < bound, 1);
    tile_valid = 1'b0;
  endtask

  task automatic zero_cnt();
    fd_cnt = 0; run = 0; max_run = 0; tr_stall = 0; rv_tr_hi = 0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_tile_ready", tile_ready, 1);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_row_last", row_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame with clipping data in tile (0,2)
    row_ready = 1'b1;
    enq(0);
    repeat (6) step();
    chk("n1_row_valid", row_valid, 1);
    chk("n1_row_idx", row_idx, 0);
    chk("n1_busy", busy, 1);
    chk("n1_tile_ready", tile_ready, PP);
    repeat (8) step();
    chk("fd_high", frame_done, 1);
    chk("after_row_valid", row_valid, 0);
    chk("after_tile_ready", tile_ready, 1);
    chk("basic_rows_left", fq.size(), 0);
    chk("basic_run", max_run, 8);
    step();
    chk("fd_low", frame_done, 0);
    chk("fd_count", fd_cnt, 1);
    chk("px_0_9", cap[0][9*DW +: DW], 16'h0201);
    chk("px_7_9", cap[7][9*DW +: DW], 16'h1231);
    chk("px_4_4", cap[4][4*DW +: DW], 16'h1100);
    chk("drain_tile_ready", rv_tr_hi, PP ? 8 : 0);

    // backpressure pattern 1,0,0,1
    zero_cnt();
    row_ready = 1'b0;
    enq(1);
    repeat (6) step();
    for (int p = 0; p < 100 && fq.size() > 0; p++) begin
      row_ready = (p % 4 == 0) || (p % 4 == 3);
      step();
    end
    chk("bp_rows_left", fq.size(), 0);
    row_ready = 1'b1;
    step();
    chk("bp_fd_count", fd_cnt, 1);

    // two frames back to back
    zero_cnt();
    enq(2);
    enq(3);
    run_all(200);
    step();
    chk("ovl_run", max_run, PP ? 16 : 8);
    chk("ovl_tile_stall", tr_stall, PP ? 0 : 8);
    chk("ovl_fd_count", fd_cnt, 2);

    // clear after 3 tiles, with a tile offered in the clear cycle
    zero_cnt();
    for (int k = 0; k < 3; k++) begin tq_tag.push_back(4); tq_k.push_back(k); end
    repeat (3) step();
    chk("pre_clear_busy", busy, 1);
    tile_valid = 1'b1;
    tile_data  = mk_tile(4, 3);
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    tile_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_tile_ready", tile_ready, 1);
    chk("clr_row_valid", row_valid, 0);
    enq(5);
    run_all(100);
    step();
    chk("clr_fd_count", fd_cnt, 1);

    // asynchronous reset while row 4 is presented
    zero_cnt();
    enq(6);
    repeat (10) step();
    chk("pre_rst_valid", row_valid, 1);
    chk("pre_rst_idx", row_idx, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_row_valid", row_valid, 0);
    chk("arst_tile_ready", tile_ready, 1);
    chk("arst_row_idx", row_idx, 0);
    chk("arst_busy", busy, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    fq.delete();
    erow = 0;
    held_v = 1'b0;
    zero_cnt();
    enq(7);
    run_all(100);
    step();
    chk("post_rst_fd_count", fd_cnt, 1);
    chk("no_clipped_data", dead_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/winograd_stitch_ctrl.md
# winograd_stitch_ctrl

Sequencing controller that collects a grid of 4x4 Winograd output tiles, clips the tiles to the 8x10 image, and streams the assembled image out one row per handshake. It sits between the Winograd output-transform engine, which supplies one tile per handshake in raster tile order, and the result writeback path. It owns the image buffer(s), the tile and row counters, and both valid/ready handshakes.

## Interface
- DATA_WIDTH, 16, element width
- TILE, 4, tile edge length
- OUT_H, 8, image rows; tile rows TR = ceil(OUT_H/TILE) = 2
- OUT_W, 10, image columns; tile cols TC = ceil(OUT_W/TILE) = 3
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort: empties all buffers and zeroes all counters
- tile_valid  in  1  tile_data valid
- tile_ready  out  1  controller can accept a tile
- tile_data  in  TILE*TILE*DATA_WIDTH  tile, row-major; element (i,j) at bits [(i*TILE+j)*DATA_WIDTH +: DATA_WIDTH]
- row_valid  out  1  row_data valid
- row_ready  in  1  downstream accepts row
- row_data  out  OUT_W*DATA_WIDTH  image row; column c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- row_idx  out  $clog2(OUT_H)  index of the presented row
- row_last  out  1  presented row is OUT_H-1
- frame_done  out  1  one-cycle pulse after the last row handshake
- busy  out  1  any buffer filling or full

## Operation
- Tile k (0..TR*TC-1) maps to tile row r = k / TC and tile col c = k % TC. Tiles arrive in raster order; the controller counts them and takes no tile index input.
- Element (i,j) of tile (r,c) is written to image[r*TILE+i][c*TILE+j] only when the row is < OUT_H and the column is < OUT_W. Other elements are discarded.
  - Example: tile (0,2) columns 2 and 3 map to image columns 10 and 11 and are dropped.
- Fill side: on each tile handshake, the tile is written into the fill buffer and the tile counter increments. On the handshake of tile TR*TC-1, the fill buffer is marked full and the tile counter wraps to 0.
- Drain side: states IDLE and DRAIN.
  - IDLE -> DRAIN when a buffer is full.
  - In DRAIN, rows 0..OUT_H-1 are presented in order. The row counter advances on each row_valid&&row_ready.
  - On the handshake of the last row, the buffer is freed, frame_done pulses, and the row counter wraps to 0.
  - After the last row, the FSM goes to DRAIN if another buffer is full, otherwise to IDLE.
- tile_ready = the fill-target buffer is not full. It is combinational from the registered full flags.
- row_data, row_idx and row_last are driven from the drain buffer and row counter. They are held stable while row_valid && !row_ready.
- busy = (tile counter != 0) || any full flag.
- clear: on the next edge, all full flags, counters and the FSM return to reset values. A tile or row handshake in the same cycle as clear is discarded and has no effect. Buffer contents are not zeroed.
- tile_valid while tile_ready=0: no effect; the upstream source holds the tile.

## Timing
- Reset values: tile_ready=1, row_valid=0, row_idx=0, row_last=0, frame_done=0, busy=0. row_data is undefined until the first fill.
- Last tile handshake at cycle N -> row_valid=1 with row_idx=0 at cycle N+1.
- With row_ready held high, one row transfers per cycle. Last row at N+OUT_H, frame_done=1 at N+OUT_H+1.
- Full throughput on the fill side: one tile per cycle while tile_ready=1.
- Ping-pong back-to-back frames: row_valid stays high across the frame boundary, and row 0 of the next frame appears the cycle after the last-row handshake.
- Reset asserted mid-frame: outputs take their reset values immediately (asynchronously); the partial frame is lost.

## Configuration
- WINO_STITCH_PINGPONG_EN defined:
  - Two image buffers. Fill alternates between buffer 0 and buffer 1; drain follows in the same order.
  - tile_ready drops only when both buffers are full.
  - Filling buffer B while draining buffer A in the same cycle is legal.
- Not defined:
  - One buffer. tile_ready=0 from the last tile handshake until the last row handshake of that frame.
  - tile_ready rises in the cycle after the last row handshake.

## Test plan
- Basic frame: load 6 tiles where element (i,j) of tile (r,c) = 16'h{r,c,i,j} (one nibble each), row_ready=1 -> row_valid at N+1 and 8 rows in order. image[0][9]=16'h0201, image[7][9]=16'h1231, image[4][4]=16'h1100; frame_done pulses once.
- Clipping: tile (0,2) with columns 2 and 3 = 16'hDEAD -> no 16'hDEAD appears in any output row.
- Backpressure: row_ready toggling 1,0,0,1 -> row_data, row_idx and row_last stay stable while stalled; no row is skipped or repeated.
- Overlap: with the macro on, stream 2 frames back-to-back with row_ready=1 -> 16 consecutive row_valid cycles and tile_ready never drops. With the macro off, tile_ready=0 during the 8 drain cycles.
- clear after 3 tiles, with tile_valid=1 in the same cycle -> busy=0 the next cycle. The next 6 tiles form a clean frame whose row 0 = tile (0,x) data.
- Reset asserted during row 4 of a drain -> row_valid=0 and tile_ready=1 immediately. The following frame outputs from row_idx=0.
